ivs_dma_wr_client: RTL and testbench

//  Upstream producer for one dwN port of the DMA write interface. Buffers a valid/ready pixel/word

---
 rtl/ivs_dma_wr_client_if.sv | 28 ++
 rtl/ivs_dma_wr_client.sv | 258 +++++++++++++++++++++++++
 tb/tb_ivs_dma_wr_client.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ivs_dma_wr_client_if.sv
// Bundles the stream input and the DMA write-port signals of one dwN client.
// master: the write client (consumes the stream, drives requests and write data).
// slave:  the side facing it (stream producer plus DMA write engine).
interface ivs_dma_wr_client_if #(
  parameter int BDWD = 128
) ();
  logic            s_valid;
  logic [BDWD-1:0] s_data;
  logic            s_ready;
  logic            dw_req;
  logic [31:0]     dw_base;
  logic [31:0]     dw_len;
  logic            dw_ack;
  logic            dw_wrdy;
  logic [BDWD-1:0] dw_wdata;
  logic            dw_valid;
  logic            dw_last;

  modport master (
    input  s_valid, s_data, dw_ack, dw_wrdy, dw_valid, dw_last,
    output s_ready, dw_req, dw_base, dw_len, dw_wdata
  );

  modport slave (
    output s_valid, s_data, dw_ack, dw_wrdy, dw_valid, dw_last,
    input  s_ready, dw_req, dw_base, dw_len, dw_wdata
  );
endinterface

// File: rtl/ivs_dma_wr_client.sv
// DMA write-port client: buffers a pixel/word stream in a show-ahead FIFO,
// cuts the frame into bursts of up to BURST_BEATS beats, issues one request
// per burst with an incrementing byte address, and serves write data as the
// engine pulls beats. Burst ends come from the internal beat count; dw_last
// is only cross-checked and a disagreement raises the sticky err flag.
module ivs_dma_wr_client #(
  parameter int BDWD        = 128,
  parameter int FIFO_AW     = 6,
  parameter int BURST_BEATS = 16
) (
  input  logic                 aclk,
  input  logic                 arst_n,
  input  logic                 cfg_start,
  input  logic [31:0]          cfg_base,
  input  logic [31:0]          cfg_beats,
  ivs_dma_wr_client_if.master  bus,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam int DEPTH   = 1 << FIFO_AW;
  localparam int BCW     = $clog2(BURST_BEATS) + 1;
  localparam int BYTE_SH = $clog2(BDWD / 8);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_FILL = 3'd1,
    ST_REQ  = 3'd2,
    ST_DATA = 3'd3,
    ST_FIN  = 3'd4
  } state_t;

  state_t            state_r;
  state_t            state_nx_s;

  logic [BDWD-1:0]   fifo_mem_r [0:DEPTH-1];
  logic [FIFO_AW-1:0] wr_ptr_r;
  logic [FIFO_AW-1:0] rd_ptr_r;
  logic [FIFO_AW:0]  fifo_cnt_r;

  logic [31:0]       cfg_beats_r;
  logic [31:0]       in_cnt_r;
  logic [31:0]       addr_r;
  logic [31:0]       rem_r;
  logic [BCW-1:0]    beat_cnt_r;

  logic              dw_req_r;
  logic [31:0]       dw_base_r;
  logic [31:0]       dw_len_r;
  logic              busy_r;
  logic              done_r;
  logic              err_r;

  logic              fifo_full_s;
  logic              s_ready_s;
  logic              push_s;
  logic              beat_s;
  logic              pop_s;
  logic              start_s;
  logic [31:0]       chunk_s;
  logic              fill_ok_s;
  logic              last_beat_s;
  logic              err_set_s;

  // The count can only reach DEPTH, so its top bit alone marks full.
  assign fifo_full_s = fifo_cnt_r[FIFO_AW];
  assign s_ready_s   = busy_r && !fifo_full_s && (in_cnt_r != cfg_beats_r);
  assign push_s      = bus.s_valid && s_ready_s;
  assign beat_s      = bus.dw_wrdy && bus.dw_valid;
  assign pop_s       = beat_s && (state_r == ST_DATA) && (fifo_cnt_r != {(FIFO_AW+1){1'b0}});
  assign start_s     = cfg_start && (state_r == ST_IDLE);
  assign fill_ok_s   = ({{(31-FIFO_AW){1'b0}}, fifo_cnt_r} >= chunk_s);
  assign last_beat_s = (beat_cnt_r == (chunk_s[BCW-1:0] - BCW'(1)));

  // Beats still owed in the current burst: min(BURST_BEATS, remaining).
  always_comb begin
    chunk_s = rem_r;
    if (rem_r >= 32'(BURST_BEATS)) begin
      chunk_s = 32'(BURST_BEATS);
    end else begin
      chunk_s = rem_r;
    end
  end

  // Protocol violations: stray ack, stray beat, or dw_last disagreeing with our count.
  always_comb begin
    err_set_s = 1'b0;
    if (bus.dw_ack && (state_r != ST_REQ)) begin
      err_set_s = 1'b1;
    end else if (beat_s && (state_r != ST_DATA)) begin
      err_set_s = 1'b1;
    end else if (beat_s && (bus.dw_last != last_beat_s)) begin
      err_set_s = 1'b1;
    end else begin
      err_set_s = 1'b0;
    end
  end

  // FIFO storage; contents are don't-care after reset so the RAM has no reset.
  always_ff @(posedge aclk) begin
    if (push_s) begin
      fifo_mem_r[wr_ptr_r] <= bus.s_data;
    end
  end

  // FIFO pointers, occupancy and accepted-word counter.
  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) begin
      wr_ptr_r   <= {FIFO_AW{1'b0}};
      rd_ptr_r   <= {FIFO_AW{1'b0}};
      fifo_cnt_r <= {(FIFO_AW+1){1'b0}};
      in_cnt_r   <= 32'd0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + FIFO_AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + FIFO_AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   fifo_cnt_r <= fifo_cnt_r + (FIFO_AW+1)'(1);
        2'b01:   fifo_cnt_r <= fifo_cnt_r - (FIFO_AW+1)'(1);
        default: fifo_cnt_r <= fifo_cnt_r;
      endcase
      if (start_s) begin
        in_cnt_r <= 32'd0;
      end else if (push_s) begin
        in_cnt_r <= in_cnt_r + 32'd1;
      end
    end
  end

  // Frame FSM state register.
  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Frame FSM next-state logic.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (cfg_start) begin
          state_nx_s = (cfg_beats == 32'd0) ? ST_FIN : ST_FILL;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_FILL: begin
        if (fill_ok_s) begin
          state_nx_s = ST_REQ;
        end else begin
          state_nx_s = ST_FILL;
        end
      end
      ST_REQ: begin
        if (bus.dw_ack) begin
          state_nx_s = ST_DATA;
        end else begin
          state_nx_s = ST_REQ;
        end
      end
      ST_DATA: begin
        if (beat_s && last_beat_s) begin
          state_nx_s = (rem_r == chunk_s) ? ST_FIN : ST_FILL;
        end else begin
          state_nx_s = ST_DATA;
        end
      end
      ST_FIN:  state_nx_s = ST_IDLE;
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // Frame bookkeeping and registered request/status outputs.
  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) begin
      cfg_beats_r <= 32'd0;
      addr_r      <= 32'd0;
      rem_r       <= 32'd0;
      beat_cnt_r  <= {BCW{1'b0}};
      dw_req_r    <= 1'b0;
      dw_base_r   <= 32'd0;
      dw_len_r    <= 32'd0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (cfg_start) begin
            cfg_beats_r <= cfg_beats;
            addr_r      <= cfg_base;
            rem_r       <= cfg_beats;
            busy_r      <= 1'b1;
          end
        end
        ST_FILL: begin
          if (fill_ok_s) begin
            dw_base_r <= addr_r;
            dw_len_r  <= chunk_s << BYTE_SH;
            dw_req_r  <= 1'b1;
          end
        end
        ST_REQ: begin
          if (bus.dw_ack) begin
            dw_req_r   <= 1'b0;
            beat_cnt_r <= {BCW{1'b0}};
          end
        end
        ST_DATA: begin
          if (beat_s) begin
            if (last_beat_s) begin
              addr_r     <= addr_r + dw_len_r;
              rem_r      <= rem_r - chunk_s;
              beat_cnt_r <= {BCW{1'b0}};
            end else begin
              beat_cnt_r <= beat_cnt_r + BCW'(1);
            end
          end
        end
        ST_FIN: begin
          done_r <= 1'b1;
          busy_r <= 1'b0;
        end
        default: begin
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  // Sticky error flag; a new frame start clears it.
  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) begin
      err_r <= 1'b0;
    end else if (start_s) begin
      err_r <= 1'b0;
    end else if (err_set_s) begin
      err_r <= 1'b1;
    end
  end

  assign bus.s_ready  = s_ready_s;
  assign bus.dw_req   = dw_req_r;
  assign bus.dw_base  = dw_base_r;
  assign bus.dw_len   = dw_len_r;
  assign bus.dw_wdata = fifo_mem_r[rd_ptr_r];
  assign busy         = busy_r;
  assign done         = done_r;
  assign err          = err_r;

endmodule

// File: tb/tb_ivs_dma_wr_client.sv
// Scoreboard bench for ivs_dma_wr_client: stimulus pushes expected requests
// and data words into queues; a monitor pops and compares on every request
// and every write beat. A small engine model acks requests and pulls beats.
`timescale 1ns/1ps
module tb_ivs_dma_wr_client;
  localparam int BDWD = 128;

  logic        aclk = 1'b0;
  logic        arst_n = 1'b0;
  logic        cfg_start = 1'b0;
  logic [31:0] cfg_base = 32'd0;
  logic [31:0] cfg_beats = 32'd0;
  logic        busy, done, err;

  ivs_dma_wr_client_if #(.BDWD(BDWD)) bus ();

  ivs_dma_wr_client #(.BDWD(BDWD), .FIFO_AW(6), .BURST_BEATS(16)) dut (
    .aclk(aclk), .arst_n(arst_n), .cfg_start(cfg_start), .cfg_base(cfg_base),
    .cfg_beats(cfg_beats), .bus(bus), .busy(busy), .done(done), .err(err)
  );

  always #5 aclk = ~aclk;

  int n_cmp = 0;
  int n_fail = 0;
  logic [BDWD-1:0] exp_data[$];
  logic [63:0]     exp_req[$];
  int done_cnt = 0;
  int beat_seen = 0;
  int cyc = 0;
  int last_beat_cyc = 0;
  int done_cyc = 0;
  int stall_len = 0;
  int bad_beat = -1;
  int nb = 0;
  logic prev_req = 1'b0;

  task automatic check(input string name, input logic [BDWD-1:0] act, input logic [BDWD-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name, input string what);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: %s", name, what);
  endtask

  function automatic logic [BDWD-1:0] mk_word(input int tid, input int i);
    return {32'hC0DE_0000 + 32'(tid), 32'(i * 3 + 7), 32'hFFFF_FFFF - 32'(i), 32'(i)};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic start(input logic [31:0] base, input logic [31:0] beats);
    cfg_base = base;
    cfg_beats = beats;
    cfg_start = 1'b1;
    tick(1);
    cfg_start = 1'b0;
  endtask

  task automatic send_words(input int n, input int tid);
    for (int i = 0; i < n; i++) begin
      int waited;
      waited = 0;
      bus.s_valid = 1'b1;
      bus.s_data = mk_word(tid, i);
      @(negedge aclk);
      while (!bus.s_ready && waited < 2000) begin
        @(negedge aclk);
        waited++;
      end
      if (!bus.s_ready) begin
        flag("s_ready_timeout", $sformatf("word %0d never accepted", i));
        bus.s_valid = 1'b0;
        tick(1);
        return;
      end
      exp_data.push_back(bus.s_data);
      tick(1);
    end
    bus.s_valid = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int k;
    k = 0;
    @(negedge aclk);
    while (!done && k < bound) begin
      @(negedge aclk);
      k++;
    end
    if (!done) flag("done_timeout", "done never pulsed");
    tick(1);
  endtask

  // Engine model: ack one cycle after seeing dw_req, then pull the burst.
  initial begin : engine
    bus.dw_ack = 1'b0;
    bus.dw_wrdy = 1'b0;
    bus.dw_valid = 1'b0;
    bus.dw_last = 1'b0;
    forever begin
      @(posedge aclk);
      #1;
      if (arst_n && bus.dw_req) begin
        nb = int'(bus.dw_len / 32'd16);
        tick(1);
        bus.dw_ack = arst_n;
        tick(1);
        bus.dw_ack = 1'b0;
        if (stall_len > 0) begin
          tick(stall_len);
          stall_len = 0;
        end
        for (int i = 0; i < nb && arst_n; i++) begin
          bus.dw_wrdy = 1'b1;
          bus.dw_valid = 1'b1;
          bus.dw_last = (i == nb - 1) || (i == bad_beat);
          tick(1);
        end
        bus.dw_wrdy = 1'b0;
        bus.dw_valid = 1'b0;
        bus.dw_last = 1'b0;
      end
    end
  end

  // Monitor: compare each new request and each write beat against the queues.
  initial begin : monitor
    logic [63:0] e;
    forever begin
      @(negedge aclk);
      cyc++;
      if (!arst_n) begin
        prev_req = 1'b0;
      end else begin
        if (bus.dw_req && !prev_req) begin
          if (exp_req.size() == 0) begin
            flag("unexpected_req", $sformatf("base %0h len %0d", bus.dw_base, bus.dw_len));
          end else begin
            e = exp_req.pop_front();
            check("req_base", bus.dw_base, e[63:32]);
            check("req_len", bus.dw_len, e[31:0]);
          end
        end
        prev_req = bus.dw_req;
        if (bus.dw_wrdy && bus.dw_valid) begin
          beat_seen++;
          last_beat_cyc = cyc;
          if (exp_data.size() == 0) flag("unexpected_beat", $sformatf("data %0h", bus.dw_wdata));
          else check("beat_data", bus.dw_wdata, exp_data.pop_front());
        end
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    flag("watchdog", "simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int b0;
    bus.s_valid = 1'b0;
    bus.s_data = '0;
    tick(3);
    // Reset values
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_s_ready", bus.s_ready, 1'b0);
    check("rst_dw_req", bus.dw_req, 1'b0);
    check("rst_dw_base", bus.dw_base, 32'h0);
    check("rst_dw_len", bus.dw_len, 32'h0);
    arst_n = 1'b1;
    tick(2);

    // 1: single 16-beat burst
    done_cnt = 0;
    exp_req.push_back({32'h0000_1000, 32'd256});
    start(32'h0000_1000, 32'd16);
    send_words(16, 1);
    wait_done(300);
    check("t1_done_cnt", done_cnt, 32'd1);
    check("t1_done_after_last", done_cyc - last_beat_cyc, 32'd2);
    check("t1_err", err, 1'b0);
    check("t1_busy", busy, 1'b0);
    check("t1_data_left", exp_data.size(), 32'd0);
    check("t1_req_left", exp_req.size(), 32'd0);

    // 2: 40 beats -> 16 + 16 + 8
    done_cnt = 0;
    exp_req.push_back({32'h0000_0000, 32'd256});
    exp_req.push_back({32'h0000_0100, 32'd256});
    exp_req.push_back({32'h0000_0200, 32'd128});
    start(32'h0000_0000, 32'd40);
    send_words(40, 2);
    bus.s_valid = 1'b1;
    bus.s_data = mk_word(2, 99);
    tick(1);
    check("t2_s_ready_after_40", bus.s_ready, 1'b0);
    check("t2_busy_mid", busy, 1'b1);
    bus.s_valid = 1'b0;
    wait_done(400);
    check("t2_done_cnt", done_cnt, 32'd1);
    check("t2_err", err, 1'b0);
    check("t2_data_left", exp_data.size(), 32'd0);
    check("t2_req_left", exp_req.size(), 32'd0);

    // 3: engine stall fills the 64-deep FIFO
    done_cnt = 0;
    stall_len = 100;
    for (int k = 0; k < 12; k++) exp_req.push_back({32'h0000_2000 + 32'(k * 256), 32'd256});
    exp_req.push_back({32'h0000_2C00, 32'd128});
    start(32'h0000_2000, 32'd200);
    fork
      send_words(200, 3);
      begin
        tick(90);
        check("t3_s_ready_full", bus.s_ready, 1'b0);
        check("t3_fifo_words", exp_data.size(), 32'd64);
      end
    join
    wait_done(2000);
    check("t3_done_cnt", done_cnt, 32'd1);
    check("t3_err", err, 1'b0);
    check("t3_data_left", exp_data.size(), 32'd0);
    check("t3_req_left", exp_req.size(), 32'd0);

    // 4: empty frame
    done_cnt = 0;
    start(32'h0000_5000, 32'd0);
    check("t4_done_early", done, 1'b0);
    check("t4_busy", busy, 1'b1);
    tick(1);
    check("t4_done_pulse", done, 1'b1);
    check("t4_busy_end", busy, 1'b0);
    tick(1);
    check("t4_done_low", done, 1'b0);
    tick(3);
    check("t4_done_cnt", done_cnt, 32'd1);

    // 5: early dw_last on beat 5
    done_cnt = 0;
    bad_beat = 5;
    b0 = beat_seen;
    exp_req.push_back({32'h0000_6000, 32'd256});
    start(32'h0000_6000, 32'd16);
    send_words(16, 5);
    wait_done(300);
    bad_beat = -1;
    check("t5_err_set", err, 1'b1);
    check("t5_beats", beat_seen - b0, 32'd16);
    check("t5_data_left", exp_data.size(), 32'd0);
    tick(5);
    check("t5_err_sticky", err, 1'b1);
    start(32'h0000_7000, 32'd0);
    check("t5_err_cleared", err, 1'b0);
    tick(4);

    // 6: reset in the middle of a burst, then a clean frame
    exp_req.push_back({32'h0000_3000, 32'd256});
    exp_req.push_back({32'h0000_3100, 32'd256});
    start(32'h0000_3000, 32'd32);
    b0 = beat_seen;
    send_words(16, 6);
    for (int k = 0; k < 200 && beat_seen < b0 + 3; k++) tick(1);
    if (beat_seen < b0 + 3) flag("t6_beat_timeout", "burst never started");
    arst_n = 1'b0;
    #1;
    check("t6_busy", busy, 1'b0);
    check("t6_done", done, 1'b0);
    check("t6_err", err, 1'b0);
    check("t6_s_ready", bus.s_ready, 1'b0);
    check("t6_dw_req", bus.dw_req, 1'b0);
    check("t6_dw_base", bus.dw_base, 32'h0);
    check("t6_dw_len", bus.dw_len, 32'h0);
    exp_data.delete();
    exp_req.delete();
    tick(3);
    arst_n = 1'b1;
    tick(2);
    done_cnt = 0;
    exp_req.push_back({32'h0000_4000, 32'd256});
    start(32'h0000_4000, 32'd16);
    send_words(16, 7);
    wait_done(300);
    check("t6_clean_done_cnt", done_cnt, 32'd1);
    check("t6_clean_err", err, 1'b0);
    check("t6_clean_data_left", exp_data.size(), 32'd0);
    check("t6_clean_req_left", exp_req.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
